// File: rtl/core_pipe_pkg.sv
// Shared pipeline boundary definitions: stage-register states, per-boundary widths
// and the E/M control/data bundle layouts.
package core_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } pipe_state_e;

    // E/M control bundle; kill-masked bits are the ones with architectural side effects
    typedef struct packed {
        logic       reg_wr_en;
        logic       result_src;
        logic       mem_wr_en;
        logic       mem_size;
        logic       mem_rd_en;
    } em_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] wr_data;
        logic [4:0]  rd_addr;
        logic [31:0] pc_plus_4;
    } em_data_t;

    localparam int unsigned F_D_DATA_W = 64;
    localparam int unsigned F_D_CTRL_W = 1;
    localparam logic [0:0]  F_D_CTRL_KILL_MASK = 1'b0;

    localparam int unsigned D_E_DATA_W = 138;
    localparam int unsigned D_E_CTRL_W = 9;
    localparam logic [8:0]  D_E_CTRL_KILL_MASK = 9'b1_0000_0101;

    localparam int unsigned E_M_DATA_W = $bits(em_data_t);
    localparam int unsigned E_M_CTRL_W = $bits(em_ctrl_t);
    localparam logic [4:0]  E_M_CTRL_KILL_MASK = 5'b10101;

    localparam int unsigned M_W_DATA_W = 101;
    localparam int unsigned M_W_CTRL_W = 2;
    localparam logic [1:0]  M_W_CTRL_KILL_MASK = 2'b10;

    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline boundary register with flush, ctrl kill-masking,
// optional two-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int unsigned        DATA_W         = E_M_DATA_W,
    parameter int unsigned        CTRL_W         = E_M_CTRL_W,
    parameter logic [CTRL_W-1:0]  CTRL_KILL_MASK = E_M_CTRL_KILL_MASK,
    parameter bit                 SKID           = 1'b0,
    parameter int unsigned        CNT_W          = STALL_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              flush_i,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CTRL_W-1:0] KEEP_MASK = ~CTRL_KILL_MASK;

    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = valid_i && ready_o;
    assign xfer_out = valid_o && ready_i;

    if (SKID) begin : g_skid
        pipe_state_e       state_q;
        logic              ready_q;
        logic [CTRL_W-1:0] skid_ctrl_q;
        logic [DATA_W-1:0] skid_data_q;

        // ready_o comes straight from a flop so ready_i never reaches upstream combinationally
        assign ready_o = ready_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q     <= EMPTY;
                ready_q     <= 1'b1;
                valid_o     <= 1'b0;
                ctrl_o      <= '0;
                data_o      <= '0;
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end else if (flush_i) begin
                state_q <= EMPTY;
                ready_q <= 1'b1;
                valid_o <= 1'b0;
                ctrl_o  <= ctrl_o & KEEP_MASK;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (xfer_in) begin
                            state_q <= FULL;
                            valid_o <= 1'b1;
                            ctrl_o  <= ctrl_i;
                            data_o  <= data_i;
                        end
                    end
                    FULL: begin
                        if (xfer_in && !xfer_out) begin
                            state_q     <= SKID_FULL;
                            ready_q     <= 1'b0;
                            skid_ctrl_q <= ctrl_i;
                            skid_data_q <= data_i;
                        end else if (xfer_in && xfer_out) begin
                            ctrl_o <= ctrl_i;
                            data_o <= data_i;
                        end else if (xfer_out) begin
                            state_q <= EMPTY;
                            valid_o <= 1'b0;
                            ctrl_o  <= ctrl_o & KEEP_MASK;
                        end
                    end
                    SKID_FULL: begin
                        if (xfer_out) begin
                            state_q <= FULL;
                            ready_q <= 1'b1;
                            ctrl_o  <= skid_ctrl_q;
                            data_o  <= skid_data_q;
                        end
                    end
                    default: begin
                        state_q <= EMPTY;
                        ready_q <= 1'b1;
                        valid_o <= 1'b0;
                        ctrl_o  <= ctrl_o & KEEP_MASK;
                    end
                endcase
            end
        end
    end else begin : g_single
        assign ready_o = ready_i || !valid_o;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_o <= 1'b0;
                ctrl_o  <= '0;
                data_o  <= '0;
            end else if (flush_i) begin
                valid_o <= 1'b0;
                ctrl_o  <= ctrl_o & KEEP_MASK;
            end else if (xfer_in) begin
                valid_o <= 1'b1;
                ctrl_o  <= ctrl_i;
                data_o  <= data_i;
            end else if (ready_i) begin
                // drained (or already empty): drop side-effect ctrl bits with valid
                valid_o <= 1'b0;
                ctrl_o  <= ctrl_o & KEEP_MASK;
            end
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (valid_o && !ready_i),
        .clr_i  (clr_cnt_i),
        .cnt_o  (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: single-register stage (4-bit counter) and skid-buffered stage.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 101;
    localparam int unsigned CW = 5;

    logic clk;
    logic rst_n;

    logic          a_valid_i, a_ready_i, a_flush, a_clr;
    logic [CW-1:0] a_ctrl_i;
    logic [DW-1:0] a_data_i;
    logic          a_valid_o, a_ready_o;
    logic [CW-1:0] a_ctrl_o;
    logic [DW-1:0] a_data_o;
    logic [3:0]    a_cnt;

    logic          b_valid_i, b_ready_i, b_flush, b_clr;
    logic [CW-1:0] b_ctrl_i;
    logic [DW-1:0] b_data_i;
    logic          b_valid_o, b_ready_o;
    logic [CW-1:0] b_ctrl_o;
    logic [DW-1:0] b_data_o;
    logic [15:0]   b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(
        .DATA_W (DW), .CTRL_W (CW), .CTRL_KILL_MASK (5'b10101), .SKID (1'b0), .CNT_W (4)
    ) u_dut_a (
        .clk_i (clk), .rst_ni (rst_n),
        .valid_i (a_valid_i), .ready_o (a_ready_o), .ctrl_i (a_ctrl_i), .data_i (a_data_i),
        .valid_o (a_valid_o), .ready_i (a_ready_i), .ctrl_o (a_ctrl_o), .data_o (a_data_o),
        .flush_i (a_flush), .clr_cnt_i (a_clr), .stall_cnt_o (a_cnt)
    );

    pipe_stage_reg #(
        .DATA_W (DW), .CTRL_W (CW), .CTRL_KILL_MASK (5'b10101), .SKID (1'b1), .CNT_W (16)
    ) u_dut_b (
        .clk_i (clk), .rst_ni (rst_n),
        .valid_i (b_valid_i), .ready_o (b_ready_o), .ctrl_i (b_ctrl_i), .data_i (b_data_i),
        .valid_o (b_valid_o), .ready_i (b_ready_i), .ctrl_o (b_ctrl_o), .data_o (b_data_o),
        .flush_i (b_flush), .clr_cnt_i (b_clr), .stall_cnt_o (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid_i = 1'b0; a_ready_i = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
        a_ctrl_i = '0; a_data_i = '0;
        b_valid_i = 1'b0; b_ready_i = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
        b_ctrl_i = '0; b_data_i = '0;

        repeat (2) step();
        check("a_rst_valid", 128'(a_valid_o), 128'(0));
        check("a_rst_ctrl",  128'(a_ctrl_o),  128'(0));
        check("a_rst_data",  128'(a_data_o),  128'(0));
        check("a_rst_cnt",   128'(a_cnt),     128'(0));
        check("b_rst_valid", 128'(b_valid_o), 128'(0));
        check("b_rst_cnt",   128'(b_cnt),     128'(0));
        rst_n = 1'b1;
        step();
        check("a_ready_after_rst", 128'(a_ready_o), 128'(1));
        check("b_ready_after_rst", 128'(b_ready_o), 128'(1));

        // pass-through and back-to-back beats on the single-register stage
        a_valid_i = 1'b1; a_ready_i = 1'b1; a_ctrl_i = 5'b11111; a_data_i = DW'('hA5);
        step();
        check("a_pt_valid", 128'(a_valid_o), 128'(1));
        check("a_pt_data",  128'(a_data_o),  128'('hA5));
        check("a_pt_ctrl",  128'(a_ctrl_o),  128'(5'b11111));
        for (int i = 1; i <= 3; i++) begin
            a_data_i = DW'(i); a_ctrl_i = CW'(i);
            step();
            check("a_b2b_valid", 128'(a_valid_o), 128'(1));
            check("a_b2b_data",  128'(a_data_o),  128'(i));
        end
        a_valid_i = 1'b0;
        step();
        check("a_drain_valid", 128'(a_valid_o), 128'(0));
        check("a_drain_ctrl_mask", 128'(a_ctrl_o), 128'(5'b00010));

        // stall: outputs freeze, counter counts stall cycles
        a_valid_i = 1'b1; a_data_i = DW'('h55); a_ctrl_i = 5'b11111;
        step();
        check("a_st_load", 128'(a_data_o), 128'('h55));
        a_ready_i = 1'b0; a_data_i = DW'('h66);
        #1;
        check("a_st_ready_low", 128'(a_ready_o), 128'(0));
        repeat (4) step();
        check("a_st_valid", 128'(a_valid_o), 128'(1));
        check("a_st_data",  128'(a_data_o),  128'('h55));
        check("a_st_ctrl",  128'(a_ctrl_o),  128'(5'b11111));
        check("a_st_cnt4",  128'(a_cnt),     128'(4));
        a_clr = 1'b1;
        step();
        check("a_clr_wins", 128'(a_cnt), 128'(0));
        a_clr = 1'b0;

        // saturation of the 4-bit counter
        repeat (20) step();
        check("a_sat15", 128'(a_cnt), 128'(15));
        step();
        check("a_sat_hold", 128'(a_cnt), 128'(15));
        check("a_sat_data", 128'(a_data_o), 128'('h55));

        // flush while holding beat 9, with beat 10 presented the same cycle
        a_ready_i = 1'b1; a_clr = 1'b1; a_data_i = DW'(9); a_ctrl_i = 5'b11111;
        step();
        check("a_fl_hold9", 128'(a_data_o), 128'(9));
        check("a_fl_clr",   128'(a_cnt),    128'(0));
        a_clr = 1'b0; a_ready_i = 1'b0; a_flush = 1'b1; a_data_i = DW'(10);
        step();
        check("a_fl_valid", 128'(a_valid_o), 128'(0));
        check("a_fl_ctrl",  128'(a_ctrl_o),  128'(5'b01010));
        check("a_fl_cnt",   128'(a_cnt),     128'(1));
        a_flush = 1'b0; a_valid_i = 1'b0; a_ready_i = 1'b1;
        step();
        check("a_fl_no10_valid", 128'(a_valid_o), 128'(0));
        check("a_fl_no10_data",  128'(a_data_o),  128'(9));

        // skid stage: fill both entries under stall, then drain in order
        b_valid_i = 1'b1; b_ready_i = 1'b0; b_ctrl_i = 5'b11111; b_data_i = DW'(7);
        step();
        check("b_sk_valid7", 128'(b_valid_o), 128'(1));
        check("b_sk_data7",  128'(b_data_o),  128'(7));
        check("b_sk_ready1", 128'(b_ready_o), 128'(1));
        b_data_i = DW'(8);
        step();
        check("b_sk_ready0", 128'(b_ready_o), 128'(0));
        check("b_sk_still7", 128'(b_data_o),  128'(7));
        check("b_sk_cnt1",   128'(b_cnt),     128'(1));
        b_valid_i = 1'b0; b_ready_i = 1'b1;
        step();
        check("b_sk_out8_valid", 128'(b_valid_o), 128'(1));
        check("b_sk_out8_data",  128'(b_data_o),  128'(8));
        check("b_sk_ready_back", 128'(b_ready_o), 128'(1));
        step();
        check("b_sk_empty",      128'(b_valid_o), 128'(0));
        check("b_sk_empty_ctrl", 128'(b_ctrl_o),  128'(5'b01010));

        // skid stage: flush out of SKID_FULL
        b_valid_i = 1'b1; b_ready_i = 1'b0; b_data_i = DW'('h21);
        step();
        b_data_i = DW'('h22);
        step();
        check("b_fl_full", 128'(b_ready_o), 128'(0));
        b_valid_i = 1'b0; b_ready_i = 1'b1; b_flush = 1'b1;
        step();
        check("b_fl_valid", 128'(b_valid_o), 128'(0));
        check("b_fl_ready", 128'(b_ready_o), 128'(1));
        b_flush = 1'b0;
        step();
        check("b_fl_no_stale", 128'(b_valid_o), 128'(0));

        // async reset mid-stream while in SKID_FULL
        b_valid_i = 1'b1; b_ready_i = 1'b0; b_data_i = DW'('h11);
        step();
        b_data_i = DW'('h12);
        step();
        check("b_ar_full", 128'(b_ready_o), 128'(0));
        check("b_ar_cnt",  128'(b_cnt),     128'(3));
        b_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("b_ar_valid", 128'(b_valid_o), 128'(0));
        check("b_ar_ctrl",  128'(b_ctrl_o),  128'(0));
        check("b_ar_cnt0",  128'(b_cnt),     128'(0));
        check("b_ar_data",  128'(b_data_o),  128'(0));
        #2 rst_n = 1'b1;
        step();
        check("b_ar_ready",     128'(b_ready_o), 128'(1));
        check("b_ar_rel_valid", 128'(b_valid_o), 128'(0));
        b_ready_i = 1'b1;
        step();
        check("b_ar_no_stale", 128'(b_valid_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
